// File: rtl/avalon_word_mem_responder.sv
// Avalon-MM slave word memory with programmable waitrequest stalls and a
// fixed-latency pipelined read return path. The per-command handshake
// (IDLE -> STALL -> ACCEPT) is carried entirely by stall_cnt_q: no command
// is IDLE, command with stall_cnt_q < WAIT_CYCLES is STALL, and the cycle
// waitrequest drops with a command present is ACCEPT. The read delay line
// runs independently of that handshake.
module avalon_word_mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] BAD_DATA     = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic        slave_waitrequest,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  output logic        err_sticky
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]       data_q [READ_LATENCY];
  logic                    err_q;

  logic              command_c;
  logic              stall_lt_c;
  logic              accept_c;
  logic              misaligned_c;
  logic              out_of_range_c;
  logic              legal_c;
  logic [IDX_W-1:0]  idx_c;
  logic              wr_do_c;
  logic              rd_acc_c;
  logic              err_set_c;
  logic [DATA_W-1:0] rd_data_c;

  // Stall threshold; with no wait cycles a command is never held off.
  if (WAIT_CYCLES == 0) begin : g_nowait
    assign stall_lt_c = 1'b0;
  end else begin : g_wait
    assign stall_lt_c = stall_cnt_q < CNT_W'(WAIT_CYCLES);
  end

  assign command_c      = slave_read | slave_write;
  assign accept_c       = command_c & ~slave_waitrequest;
  assign misaligned_c   = |slave_address[1:0];
  assign out_of_range_c = |slave_address[31:IDX_W+2];
  assign legal_c        = ~misaligned_c & ~out_of_range_c;
  assign idx_c          = slave_address[IDX_W+1:2];

  // Only a lone read or lone write to a legal word performs an access.
  assign wr_do_c   = accept_c & slave_write & ~slave_read & legal_c;
  assign rd_acc_c  = accept_c & slave_read & ~slave_write;
  assign err_set_c = accept_c & ((slave_read & slave_write) | ~legal_c);

  // Waitrequest is held during reset so nothing is accepted then.
  assign slave_waitrequest = rst | (command_c & stall_lt_c);

  // Next stall count: count stalled cycles, restart on accept or idle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!command_c || accept_c) begin
      stall_cnt_d = '0;
    end else begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Data captured into the first delay stage; zero unless a read is accepted.
  always_comb begin
    rd_data_c = '0;
    if (rd_acc_c) begin
      rd_data_c = legal_c ? mem_q[idx_c] : BAD_DATA;
    end
  end

  // Word storage; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_do_c) begin
      mem_q[idx_c] <= slave_writedata;
    end
  end

  // Stall counter, read delay line and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      vld_q       <= '0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      stall_cnt_q <= stall_cnt_d;
      vld_q[0]    <= rd_acc_c;
      data_q[0]   <= rd_data_c;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
      err_q <= err_q | err_set_c;
    end
  end

  // Responses are suppressed while reset is held.
  assign slave_readdatavalid = vld_q[READ_LATENCY-1] & ~rst;
  assign slave_readdata      = rst ? '0 : data_q[READ_LATENCY-1];
  assign err_sticky          = err_q & ~rst;

endmodule

// File: doc/avalon_word_mem_responder.md
Name: avalon_word_mem_responder

Overview:
- Synthesizable Avalon-MM slave word memory. It is the responder end of the master (SDRAM-facing) port used by our accelerators such as the word-copy engine.
- Provides configurable waitrequest stalls and fixed-latency pipelined reads (readdatavalid), so master FSMs are exercised against realistic SDRAM-like timing.
- Used in system simulation and on-chip as a scratch buffer in place of SDRAM.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 4.
- WAIT_CYCLES, 1, cycles waitrequest stays high for each new command before acceptance; 0 to 15.
- READ_LATENCY, 2, cycles from read acceptance to readdatavalid; 1 to 8.
- BAD_DATA, 32'hDEADBEEF, readdata returned for an illegal read address.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- slave_address  in  32  byte address; word index = address[log2(DEPTH_WORDS)+1:2].
- slave_read  in  1  read command.
- slave_write  in  1  write command.
- slave_writedata  in  32  write data.
- slave_waitrequest  out  1  command not accepted this cycle; master holds command stable.
- slave_readdata  out  32  read data, valid only with readdatavalid, otherwise 0.
- slave_readdatavalid  out  1  one-cycle pulse per accepted read.
- err_sticky  out  1  set on any illegal access; cleared only by rst.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - While rst is high: waitrequest=1, readdatavalid=0, readdata=0, err_sticky=0.
  - Stall counter and read delay line are cleared.
  - Memory contents are NOT cleared.
- Command = slave_read | slave_write. Accept = command & !waitrequest, sampled on posedge.
- Stall control:
  - stall_cnt (4 bits) increments each cycle a command is present with waitrequest=1.
  - waitrequest = command & (stall_cnt < WAIT_CYCLES). It is combinational; with WAIT_CYCLES=0 a command is accepted the cycle it appears.
  - stall_cnt clears on accept, or on any cycle with no command (command withdrawn mid-stall: no access, no error).
  - Back-to-back commands each incur WAIT_CYCLES stall cycles.
  - waitrequest=0 when there is no command (except during reset).
- Write:
  - On the accept edge, mem[index] <= writedata.
  - A read accepted on the following cycle returns the new data. No write-to-read hazard.
- Read:
  - Memory is sampled on the accept edge and the data enters a READ_LATENCY-deep delay line (valid+data per stage).
  - For a read accepted at edge T, readdatavalid=1 and readdata=data during cycle T+READ_LATENCY (READ_LATENCY=1: the cycle right after accept).
  - Up to one read is accepted per cycle, so up to READ_LATENCY reads can be in flight. Responses are in order and never dropped.
  - The slave has no backpressure on responses.
- Illegal accesses (the command is still accepted with normal stall timing):
  - address[1:0] != 0 → misaligned.
  - address>>2 >= DEPTH_WORDS → out of range.
  - Illegal write: dropped, err_sticky=1.
  - Illegal read: returns BAD_DATA with normal readdatavalid timing, err_sticky=1.
  - read & write both high: command accepted, neither performed, err_sticky=1, no readdatavalid.
- Reset mid-operation: in-flight reads are discarded. No readdatavalid while rst is high or on the first cycle after rst falls. Writes accepted before rst keep their data.
- FSM per command: IDLE (no command) → STALL (stall_cnt < WAIT_CYCLES) → ACCEPT (one cycle) → IDLE or STALL. Read pipeline runs independently of the FSM.

Test Plan:
- WAIT_CYCLES=1, READ_LATENCY=2: write 0x11111111..0x44444444 to bytes 0x00..0x0C, then read 0x08 → waitrequest high exactly 1 cycle per command; readdata=0x33333333 with valid 2 cycles after the accept edge.
- Copy-engine pattern: write 0xCAFEF00D to 0x40, then immediately read 0x40 → returns 0xCAFEF00D; err_sticky stays 0.
- WAIT_CYCLES=0, READ_LATENCY=3: 4 back-to-back reads of 0x0,0x4,0x8,0xC with read held high → waitrequest never asserted; 4 consecutive valid pulses starting 3 cycles after the first accept, data in order.
- Illegal access: read 0x02, then read at DEPTH_WORDS*4, then write 0x401 → two BAD_DATA responses with valid; err_sticky=1 after the first; mem[0] unchanged.
- Reset mid-read: accept read of 0x00 (READ_LATENCY=4), assert rst 2 cycles later for 1 cycle → no readdatavalid at all; subsequent read of 0x00 returns the pre-reset written value.
- Withdrawn command: WAIT_CYCLES=3, assert write for 2 cycles then drop → memory unchanged; next command again stalls a full 3 cycles.
